// File: rtl/row_gauss5.sv
// Horizontal 5-tap symmetric Gaussian on a raster pixel stream.
// Edge pixels are replicated at both line borders. A fill/run/flush FSM frames each line.
// The result comes out two cycles after the window-completing accept or flush cycle.
// Optional build macro ROW_GAUSS5_BYPASS_EN adds the byp input. When byp is high the
// output becomes p[x] * (2*C0 + 2*C1 + C2), which keeps the gain of the filter.
module row_gauss5 #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4,
  parameter int unsigned C0 = 1,
  parameter int unsigned C1 = 4,
  parameter int unsigned C2 = 6,
  parameter int unsigned OW = 16
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          din_vld,
  output logic          din_rdy,
  input  logic [DW-1:0] din,
  input  logic          din_sol,
  input  logic          din_eol,
`ifdef ROW_GAUSS5_BYPASS_EN
  input  logic          byp,
`endif
  output logic          dout_vld,
  output logic [OW-1:0] dout,
  output logic          dout_sol,
  output logic          dout_eol,
  output logic          err
);

  localparam int unsigned SW = DW + 1;       // pair sum
  localparam int unsigned PW = DW + CW + 1;  // product
  localparam int unsigned TW = DW + CW + 3;  // total

  localparam logic [CW-1:0] K0 = CW'(C0);
  localparam logic [CW-1:0] K1 = CW'(C1);
  localparam logic [CW-1:0] K2 = CW'(C2);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

  state_e state_q, state_d;

  // Index 0 holds w[-2], index 4 holds w[+2]; an accept shifts din in at index 4.
  logic [4:0][DW-1:0] win_q, win_d;
  logic               fill_q, fill_d;    // 0: waiting for p1, 1: waiting for p2
  logic               flush_q, flush_d;  // which of the two flush cycles
  logic               err_q, err_d;

  logic accept;
  logic start_line;
  logic iss, iss_sol, iss_eol;

  // Stage 1 operands and registers
  logic [SW-1:0] pair_a, pair_b;
  logic [DW-1:0] ctr;
  logic [PW-1:0] pa_d, pb_d, pc_d;
  logic [PW-1:0] pa_q, pb_q, pc_q;
  logic          vld1_q, sol1_q, eol1_q;

  // Stage 2 registers
  logic [TW-1:0] total;
  logic [OW-1:0] dout_q;
  logic          vld2_q, sol2_q, eol2_q;

  // Reset holds din_rdy low. Ready drops only during the two flush cycles.
  assign din_rdy = rst_b && (state_q != StFlush);
  assign accept  = din_vld && din_rdy;

  // Framing FSM next state, window update and compute issue
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    fill_d     = fill_q;
    flush_d    = flush_q;
    err_d      = 1'b0;
    start_line = 1'b0;
    iss        = 1'b0;
    iss_sol    = 1'b0;
    iss_eol    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Non-sol accepts are dropped here.
        if (accept && din_sol) start_line = 1'b1;
      end
      StFill: begin
        if (accept) begin
          if (din_sol) begin
            err_d      = 1'b1;
            start_line = 1'b1;
          end else begin
            win_d = {din, win_q[4:1]};
            if (!fill_q) begin
              if (din_eol) begin
                // A 2-pixel line produces no output.
                err_d   = 1'b1;
                state_d = StIdle;
              end else begin
                fill_d = 1'b1;
              end
            end else begin
              iss     = 1'b1;
              iss_sol = 1'b1;
              if (din_eol) begin
                state_d = StFlush;
                flush_d = 1'b0;
              end else begin
                state_d = StRun;
              end
            end
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (din_sol) begin
            // Abort the current line. Computes already issued drain normally.
            err_d      = 1'b1;
            start_line = 1'b1;
          end else begin
            win_d = {din, win_q[4:1]};
            iss   = 1'b1;
            if (din_eol) begin
              state_d = StFlush;
              flush_d = 1'b0;
            end
          end
        end
      end
      StFlush: begin
        // Replicate the last pixel to cover p[L] and p[L+1].
        win_d = {win_q[4], win_q[4:1]};
        iss   = 1'b1;
        if (flush_q) begin
          iss_eol = 1'b1;
          flush_d = 1'b0;
          state_d = StIdle;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_line) begin
      win_d = {5{din}};
      if (din_eol) begin
        err_d   = 1'b1;
        state_d = StIdle;
      end else begin
        state_d = StFill;
        fill_d  = 1'b0;
      end
    end
  end

  // FSM state, window and error pulse registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      win_q   <= '0;
      fill_q  <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  // Stage 1 operands come from the window as it stands after this cycle's update.
  always_comb begin
    pair_a = SW'(win_d[0]) + SW'(win_d[4]);
    pair_b = SW'(win_d[1]) + SW'(win_d[3]);
    ctr    = win_d[2];
`ifdef ROW_GAUSS5_BYPASS_EN
    // Bypass: both pair sums become 2*centre, so the sum is p[x] times the full gain.
    if (byp) begin
      pair_a = {ctr, 1'b0};
      pair_b = {ctr, 1'b0};
    end
`endif
    pa_d = PW'(pair_a) * PW'(K0);
    pb_d = PW'(pair_b) * PW'(K1);
    pc_d = PW'(ctr) * PW'(K2);
  end

  assign total = TW'(pa_q) + TW'(pb_q) + TW'(pc_q);

  // Two-stage arithmetic pipeline. dout holds its value between valid outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pa_q   <= '0;
      pb_q   <= '0;
      pc_q   <= '0;
      vld1_q <= 1'b0;
      sol1_q <= 1'b0;
      eol1_q <= 1'b0;
      dout_q <= '0;
      vld2_q <= 1'b0;
      sol2_q <= 1'b0;
      eol2_q <= 1'b0;
    end else begin
      vld1_q <= iss;
      sol1_q <= iss_sol;
      eol1_q <= iss_eol;
      if (iss) begin
        pa_q <= pa_d;
        pb_q <= pb_d;
        pc_q <= pc_d;
      end
      vld2_q <= vld1_q;
      sol2_q <= sol1_q;
      eol2_q <= eol1_q;
      if (vld1_q) dout_q <= OW'(total);
    end
  end

  assign dout_vld = vld2_q;
  assign dout     = dout_q;
  assign dout_sol = sol2_q;
  assign dout_eol = eol2_q;
  assign err      = err_q;

endmodule

// File: tb/tb_row_gauss5.sv
// Scoreboard bench for row_gauss5. Directed lines push their expected outputs into a queue.
// A negedge monitor pops and compares each one as the DUT presents it.
module tb_row_gauss5;

  localparam int DW = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          din_vld = 1'b0;
  logic          din_rdy;
  logic [DW-1:0] din = '0;
  logic          din_sol = 1'b0;
  logic          din_eol = 1'b0;
  logic          dout_vld;
  logic [OW-1:0] dout;
  logic          dout_sol;
  logic          dout_eol;
  logic          err;
`ifdef ROW_GAUSS5_BYPASS_EN
  logic          byp = 1'b0;
`endif

  row_gauss5 dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .din      (din),
    .din_sol  (din_sol),
    .din_eol  (din_eol),
`ifdef ROW_GAUSS5_BYPASS_EN
    .byp      (byp),
`endif
    .dout_vld (dout_vld),
    .dout     (dout),
    .dout_sol (dout_sol),
    .dout_eol (dout_eol),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          s;
    logic          e;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          got_e;
  logic [DW-1:0] line_pix [16];
  int            exp_val [16];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            err_cnt = 0;
  int            sol_cyc = -1;
  int            last_acc_cyc = 0;
  int            p2_cyc = 0;
  int            e0 = 0;
  int            low = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count err cycles and check every presented output against the queue
  always @(negedge clk) begin
    if (rst_b && err) err_cnt++;
    if (rst_b && dout_vld) begin
      checks++;
      if (dout_sol) sol_cyc = cyc;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output dout=%0d sol=%b eol=%b required=none",
                 dout, dout_sol, dout_eol);
      end else begin
        got_e = exp_q.pop_front();
        if ({dout, dout_sol, dout_eol} !== got_e) begin
          failures++;
          $display("FAIL scoreboard dout=%0d sol=%b eol=%b required dout=%0d sol=%b eol=%b",
                   dout, dout_sol, dout_eol, got_e.d, got_e.s, got_e.e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send_pixel(input logic [DW-1:0] p, input logic s, input logic e);
    int waited;
    waited = 0;
    @(negedge clk);
    din_vld = 1'b1;
    din     = p;
    din_sol = s;
    din_eol = e;
    #1;
    while (!din_rdy && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("accept_within_budget", int'(din_rdy), 1);
    @(posedge clk);
    last_acc_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    din_vld = 1'b0;
    din_sol = 1'b0;
    din_eol = 1'b0;
  endtask

  task automatic send_line(input int n, input logic with_eol);
    for (int i = 0; i < n; i++) begin
      send_pixel(line_pix[i], i == 0, with_eol && (i == n - 1));
      if (i == 2) p2_cyc = last_acc_cyc;
    end
  endtask

  task automatic push_exp(input int n, input logic with_eol);
    for (int i = 0; i < n; i++)
      exp_q.push_back({OW'(exp_val[i]), i == 0, with_eol && (i == n - 1)});
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic load_ramp();
    int r [8];
    r = '{60, 170, 320, 480, 640, 800, 950, 1060};
    for (int i = 0; i < 8; i++) begin
      line_pix[i] = DW'(10 * i);
      exp_val[i]  = r[i];
    end
  endtask

  initial begin
    int imp_pix [5];
    int imp_exp [5];
    int b_exp [5];
    imp_pix = '{0, 0, 255, 0, 0};
    imp_exp = '{255, 1020, 1530, 1020, 255};
    b_exp   = '{352, 528, 768, 1008, 1184};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout_vld", int'(dout_vld), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_din_rdy", int'(din_rdy), 0);
    chk("rst_dout_sol_eol", int'({dout_sol, dout_eol}), 0);
    rst_b = 1'b1;
    #1;
    chk("rdy_after_release", int'(din_rdy), 1);

    // Constant line L=8
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) begin
      line_pix[i] = 8'd100;
      exp_val[i]  = 1600;
    end
    push_exp(8, 1'b1);
    send_line(8, 1'b1);
    low = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        din_vld = 1'b0;
        din_sol = 1'b0;
        din_eol = 1'b0;
      end
      #1;
      if (!din_rdy) low++;
    end
    chk("flush_rdy_low_cycles", low, 2);
    wait_drain();
    chk("first_out_latency", sol_cyc - p2_cyc, 2);
    chk("const_err", err_cnt - e0, 0);

    // Line of length 2: no output, one err pulse
    e0 = err_cnt;
    line_pix[0] = 8'd50;
    line_pix[1] = 8'd60;
    send_line(2, 1'b1);
    idle();
    repeat (4) @(negedge clk);
    chk("len2_err_pulse", err_cnt - e0, 1);

    // Impulse line, right after the short line
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) begin
      line_pix[i] = DW'(imp_pix[i]);
      exp_val[i]  = imp_exp[i];
    end
    push_exp(5, 1'b1);
    send_line(5, 1'b1);
    idle();
    wait_drain();
    chk("impulse_err", err_cnt - e0, 0);

    // Ramp line with replicated borders
    e0 = err_cnt;
    load_ramp();
    push_exp(8, 1'b1);
    send_line(8, 1'b1);
    idle();
    wait_drain();
    chk("ramp_err", err_cnt - e0, 0);

    // Line A aborted after 4 pixels by the sol of line B
    e0 = err_cnt;
    exp_q.push_back({16'd220, 1'b1, 1'b0});
    exp_q.push_back({16'd330, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) exp_val[i] = b_exp[i];
    push_exp(5, 1'b1);
    for (int i = 0; i < 4; i++) line_pix[i] = DW'(10 * (i + 1));
    send_line(4, 1'b0);
    for (int i = 0; i < 5; i++) line_pix[i] = DW'(16 * (i + 1));
    send_line(5, 1'b1);
    idle();
    wait_drain();
    chk("abort_err_pulse", err_cnt - e0, 1);

    // Async reset in the middle of RUN
    exp_q.push_back({16'd1600, 1'b1, 1'b0});
    exp_q.push_back({16'd1600, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) send_pixel(8'd100, i == 0, 1'b0);
    #1;
    chk("pre_reset_vld", int'(dout_vld), 1);
    chk("pre_reset_dout", int'(dout), 1600);
    rst_b   = 1'b0;
    din_vld = 1'b0;
    din_sol = 1'b0;
    #1;
    chk("mid_rst_dout_vld", int'(dout_vld), 0);
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_din_rdy", int'(din_rdy), 0);
    chk("mid_rst_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rdy_after_mid_release", int'(din_rdy), 1);
    e0 = err_cnt;
    load_ramp();
    push_exp(8, 1'b1);
    send_line(8, 1'b1);
    idle();
    wait_drain();
    chk("post_reset_err", err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
